// File: rtl/alu_issue.sv
// alu_issue -- operand-issue stage in front of the 32-bit ALU.
//
// Decodes one RV32I instruction per accepted transfer into the ALU control
// code and the two ALU operands. The result is registered behind a
// valid/ready handshake with a two-entry skid buffer, so the outputs feed the
// ALU directly with no further logic.
//
// Optional feature: define ALU_ISSUE_FWD_EN to forward the ALU write-back
// result (fwd_*) onto rs1/rs2 in the accept cycle. Without it the fwd_* ports
// are present but ignored.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready is a pure state decode
//   instr, pc           instruction word and its address
//   rs1_data, rs2_data  register-file read values
//   fwd_valid/rd/data   ALU write-back result, for optional forwarding
//   out_valid/out_ready downstream handshake towards the ALU
//   a, b, aluctr        ALU operands and control code
//   rd                  destination register, 0 when there is none
//   illegal             unsupported opcode (still transfers normally)

module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      aluctr,
    output logic [4:0]      rd,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] CTL_ADD  = 4'b0000;
    localparam logic [3:0] CTL_SUB  = 4'b1000;
    localparam logic [3:0] CTL_SLT  = 4'b0010;
    localparam logic [3:0] CTL_SLTU = 4'b0011;
    localparam logic [3:0] CTL_PASS = 4'b1111;

    // One decoded operation; the skid entry is stored in this form too.
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      ctl;
        logic [4:0]      rd;
        logic            ill;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state, state_next;
    entry_t          dec, out_q, skid_q;
    logic            accept, consume;
    logic            load_out, load_skid, out_from_skid;
    logic [XLEN-1:0] src1, src2;

    // ---------------------------------------------------------------- forwarding
`ifdef ALU_ISSUE_FWD_EN
    // x0 is never forwarded: it always reads as zero from the register file.
    assign src1 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == instr[19:15]) ? fwd_data : rs1_data;
    assign src2 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == instr[24:20]) ? fwd_data : rs2_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
    assign src1 = rs1_data;
    assign src2 = rs2_data;
`endif

    // -------------------------------------------------------------------- decode
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_u;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'b0};

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        dec = '0;
        unique case (opcode)
            OPC_OP: begin
                dec.a   = src1;
                dec.b   = src2;
                // funct7[5] only distinguishes sub and sra.
                dec.ctl = {(funct3 == 3'b000 || funct3 == 3'b101) & instr[30], funct3};
                dec.rd  = instr[11:7];
            end
            OPC_OP_IMM: begin
                dec.a   = src1;
                dec.b   = (funct3 == 3'b001 || funct3 == 3'b101)
                          ? {{(XLEN-5){1'b0}}, instr[24:20]} : imm_i;
                dec.ctl = {(funct3 == 3'b101) & instr[30], funct3};
                dec.rd  = instr[11:7];
            end
            OPC_LUI: begin
                dec.b   = imm_u;
                dec.ctl = CTL_PASS;
                dec.rd  = instr[11:7];
            end
            OPC_AUIPC: begin
                dec.a   = pc;
                dec.b   = imm_u;
                dec.ctl = CTL_ADD;
                dec.rd  = instr[11:7];
            end
            OPC_JAL, OPC_JALR: begin
                // Link value pc+4 is computed by the ALU.
                dec.a   = pc;
                dec.b   = XLEN'(4);
                dec.ctl = CTL_ADD;
                dec.rd  = instr[11:7];
            end
            OPC_LOAD: begin
                dec.a   = src1;
                dec.b   = imm_i;
                dec.ctl = CTL_ADD;
                dec.rd  = instr[11:7];
            end
            OPC_STORE: begin
                dec.a   = src1;
                dec.b   = imm_s;
                dec.ctl = CTL_ADD;
            end
            OPC_BRANCH: begin
                dec.a = src1;
                dec.b = src2;
                unique case (funct3[2:1])
                    2'b10:   dec.ctl = CTL_SLT;
                    2'b11:   dec.ctl = CTL_SLTU;
                    default: dec.ctl = CTL_SUB;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------- skid FSM
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        unique case (state)
            EMPTY: if (accept) begin
                load_out   = 1'b1;
                state_next = ONE;
            end
            ONE: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (consume) begin
                    state_next = EMPTY;
                end
            end
            FULL: if (consume) begin
                out_from_skid = 1'b1;
                state_next    = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: the data registers are reset as well because the outputs drive the
    // ALU directly and must read as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out)           out_q <= dec;
            else if (out_from_skid) out_q <= skid_q;
            if (load_skid)          skid_q <= dec;
        end
    end

    assign a       = out_q.a;
    assign b       = out_q.b;
    assign aluctr  = out_q.ctl;
    assign rd      = out_q.rd;
    assign illegal = out_q.ill;

endmodule
